// File: rtl/trap_ctrl_if.sv
// Commit/CSR/fetch-side bundle of the trap sequencer.
// master: commit stage + CSR file + fetch (drives events, CSR values, flush_ack).
// slave : trap_ctrl (drives flush/busy, CSR write strobes and the PC redirect).
interface trap_ctrl_if #(
  parameter int XLEN = 64
);
  // Current machine state from the CSR file
  logic [1:0]      pmode;
  logic [XLEN-1:0] mstatus;
  logic [XLEN-1:0] mie;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;

  // Asynchronous interrupt lines
  logic            irq_ext;
  logic            irq_sw;
  logic            irq_timer;

  // Commit-stage events
  logic            commit_valid;
  logic [XLEN-1:0] commit_next_pc;
  logic            exc_valid;
  logic [5:0]      exc_cause;
  logic [XLEN-1:0] exc_pc;
  logic [XLEN-1:0] exc_tval;
  logic            mret_valid;

  // Pipeline drain handshake
  logic            flush_req;
  logic            flush_ack;
  logic            busy;

  // CSR write command and fetch redirect
  logic            trap_we;
  logic            mret_we;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] trap_epc;
  logic [XLEN-1:0] trap_tval;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [1:0]      new_pmode;
  logic            update_pmode;

  modport master (
    output pmode, mstatus, mie, mtvec, mepc,
           irq_ext, irq_sw, irq_timer,
           commit_valid, commit_next_pc, exc_valid, exc_cause, exc_pc, exc_tval,
           mret_valid, flush_ack,
    input  flush_req, busy, trap_we, mret_we, trap_cause, trap_epc, trap_tval,
           redirect_valid, redirect_pc, new_pmode, update_pmode
  );

  modport slave (
    input  pmode, mstatus, mie, mtvec, mepc,
           irq_ext, irq_sw, irq_timer,
           commit_valid, commit_next_pc, exc_valid, exc_cause, exc_pc, exc_tval,
           mret_valid, flush_ack,
    output flush_req, busy, trap_we, mret_we, trap_cause, trap_epc, trap_tval,
           redirect_valid, redirect_pc, new_pmode, update_pmode
  );
endinterface

// File: rtl/trap_ctrl.sv
// Trap sequencer: picks exception > MRET > interrupt (MEI>MSI>MTI) at commit, drains, writes CSRs.
// Latency: event in cycle N -> flush_req from N+1; flush_ack at N+1 -> single-cycle strobes at N+2.
// Backpressure: holds in DRAIN (busy=1, commit stalls) until flush_ack; events while busy are ignored.
//
// Ports: clk, rst (async active-low); bus (trap_ctrl_if.slave) carries CSR state, irq lines,
// commit events, flush_req/flush_ack/busy, trap_we/mret_we + cause/epc/tval, redirect and pmode.
// Optional build macro TRAP_CTRL_VECTORED_EN: vectored interrupt entry when mtvec[1:0]==1.
module trap_ctrl #(
  parameter int XLEN        = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  trap_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t state, state_nx;

  // Interrupt line synchronizers, bit order {ext, sw, timer}
  logic [2:0] irq_sync [SYNC_STAGES];
  logic [2:0] irq_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) irq_sync[i] <= 3'b000;
    end else begin
      irq_sync[0] <= {bus.irq_ext, bus.irq_sw, bus.irq_timer};
      for (int i = 1; i < SYNC_STAGES; i++) irq_sync[i] <= irq_sync[i-1];
    end
  end

  assign irq_s = irq_sync[SYNC_STAGES-1];

  // Interrupt qualification
  logic [2:0] pending;
  logic       int_enable;
  logic [5:0] int_code;

  assign pending    = {irq_s[2] & bus.mie[11], irq_s[1] & bus.mie[3], irq_s[0] & bus.mie[7]};
  // Lower privilege always takes machine interrupts; in M-mode only with MIE set
  assign int_enable = (bus.pmode != 2'd3) || bus.mstatus[3];

  always_comb begin
    int_code = 6'd7;
    if (pending[2]) begin
      int_code = 6'd11;
    end else if (pending[1]) begin
      int_code = 6'd3;
    end
  end

  // Captured trap record
  logic            is_mret_q, is_mret_nx;
  logic [XLEN-1:0] cause_q, cause_nx;
  logic [XLEN-1:0] epc_q, epc_nx;
  logic [XLEN-1:0] tval_q, tval_nx;

  // Registered outputs
  logic            flush_req_q;
  logic            busy_q;
  logic            trap_we_q;
  logic            mret_we_q;
  logic            redirect_valid_q;
  logic            update_pmode_q;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_nx;
  logic [1:0]      new_pmode_q, new_pmode_nx;
  logic            enter_commit;

  // Trap entry target
  logic [XLEN-1:0] trap_base;
  logic [XLEN-1:0] trap_target;

  assign trap_base = {bus.mtvec[XLEN-1:2], 2'b00};

`ifdef TRAP_CTRL_VECTORED_EN
  logic [XLEN-1:0] vec_offset;
  assign vec_offset  = {{(XLEN-8){1'b0}}, cause_q[5:0], 2'b00};
  // Only interrupts (cause MSB set) vector, and only in mode 1; modes 2/3 behave as direct
  assign trap_target = (cause_q[XLEN-1] && (bus.mtvec[1:0] == 2'b01)) ?
                       (trap_base + vec_offset) : trap_base;
`else
  assign trap_target = trap_base;
`endif

  // CSR bits not consumed here
  logic unused_bits;
  assign unused_bits = ^{bus.mstatus, bus.mie, bus.mtvec[1:0]};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state, capture and redirect computation
  always_comb begin
    state_nx       = state;
    is_mret_nx     = is_mret_q;
    cause_nx       = cause_q;
    epc_nx         = epc_q;
    tval_nx        = tval_q;
    redirect_pc_nx = redirect_pc_q;
    new_pmode_nx   = new_pmode_q;
    enter_commit   = 1'b0;

    case (state)
      IDLE: begin
        if (bus.exc_valid) begin
          is_mret_nx = 1'b0;
          cause_nx   = {{(XLEN-6){1'b0}}, bus.exc_cause};
          epc_nx     = bus.exc_pc;
          tval_nx    = bus.exc_tval;
          state_nx   = DRAIN;
        end else if (bus.mret_valid) begin
          // MRET leaves the captured record untouched
          is_mret_nx = 1'b1;
          state_nx   = DRAIN;
        end else if (bus.commit_valid && int_enable && (pending != 3'b000)) begin
          is_mret_nx         = 1'b0;
          cause_nx           = '0;
          cause_nx[XLEN-1]   = 1'b1;
          cause_nx[5:0]      = int_code;
          epc_nx             = bus.commit_next_pc;
          tval_nx            = '0;
          state_nx           = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.flush_ack) begin
          state_nx     = COMMIT;
          enter_commit = 1'b1;
        end
      end
      COMMIT: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    // Redirect/pmode are sampled from the CSR file on the DRAIN->COMMIT edge
    if (enter_commit) begin
      if (is_mret_q) begin
        redirect_pc_nx = bus.mepc;
        new_pmode_nx   = bus.mstatus[12:11];
      end else begin
        redirect_pc_nx = trap_target;
        new_pmode_nx   = 2'd3;
      end
    end
  end

  // Capture and output registers; strobes are decoded from the next state so they are flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_mret_q        <= 1'b0;
      cause_q          <= '0;
      epc_q            <= '0;
      tval_q           <= '0;
      flush_req_q      <= 1'b0;
      busy_q           <= 1'b0;
      trap_we_q        <= 1'b0;
      mret_we_q        <= 1'b0;
      redirect_valid_q <= 1'b0;
      update_pmode_q   <= 1'b0;
      redirect_pc_q    <= '0;
      new_pmode_q      <= 2'd0;
    end else begin
      is_mret_q        <= is_mret_nx;
      cause_q          <= cause_nx;
      epc_q            <= epc_nx;
      tval_q           <= tval_nx;
      flush_req_q      <= (state_nx == DRAIN);
      busy_q           <= (state_nx != IDLE);
      trap_we_q        <= (state_nx == COMMIT) && !is_mret_nx;
      mret_we_q        <= (state_nx == COMMIT) && is_mret_nx;
      redirect_valid_q <= (state_nx == COMMIT);
      update_pmode_q   <= (state_nx == COMMIT);
      redirect_pc_q    <= redirect_pc_nx;
      new_pmode_q      <= new_pmode_nx;
    end
  end

  assign bus.flush_req      = flush_req_q;
  assign bus.busy           = busy_q;
  assign bus.trap_we        = trap_we_q;
  assign bus.mret_we        = mret_we_q;
  assign bus.trap_cause     = cause_q;
  assign bus.trap_epc       = epc_q;
  assign bus.trap_tval      = tval_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.new_pmode      = new_pmode_q;
  assign bus.update_pmode   = update_pmode_q;

endmodule
